mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 6 +
 rtl/mem_array.sv | 17 +
 rtl/mem_responder.sv | 78 +++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and widths for the memory responder
package mem_resp_pkg;
    localparam int DW = 8;
    localparam int CW = 4;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: byte storage with synchronous write and registered read, no reset
module mem_array import mem_resp_pkg::*; #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] q
);
    logic [DW-1:0] m [2**AW];
    always_ff @(posedge clk) begin
        if (we) m[a] <= wd;
        if (re) q <= m[a];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder; MEM_RESP_WP_EN blocks writes below WP_TOP
module mem_responder import mem_resp_pkg::*; #(
    parameter int            AW     = 8,
    parameter int            WAIT   = 2,
    parameter logic [AW-1:0] WP_TOP = AW'(8'h40)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic          ready,
    output logic          err
);
`ifdef MEM_RESP_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif
    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] alat, a_n;
    logic [DW-1:0] dlat, d_n, q;
    logic          op_r, op_w, rd_ok;
    logic          idle, go, fin, r_n, w_n, wp, we, re;
    // with WAIT=0 the accepting edge is also the DONE-entry edge, so the live request is used
    always_comb begin
        idle = state == IDLE;
        go   = idle && (memread || memwrite);
        r_n  = idle ? memread : op_r;
        w_n  = idle ? memwrite : op_w;
        a_n  = idle ? adr : alat;
        d_n  = idle ? wd : dlat;
        fin  = (go && WAIT == 0) || (state == mem_resp_pkg::WAIT && cnt == CW'(1));
        wp   = WP_EN && (a_n < WP_TOP);
        we   = reset && fin && w_n && !r_n && !wp;
        re   = reset && fin && r_n && !w_n;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            alat  <= '0;
            dlat  <= '0;
            op_r  <= 1'b0;
            op_w  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            ready <= fin;
            err   <= fin && w_n && (r_n || wp);
            if (re) rd_ok <= 1'b1;
            if (go) begin
                alat <= adr;
                dlat <= wd;
                op_r <= memread;
                op_w <= memwrite;
                cnt  <= CW'(WAIT);
            end else if (state == mem_resp_pkg::WAIT) begin
                cnt <= cnt - CW'(1);
            end
            state <= fin ? DONE : go ? mem_resp_pkg::WAIT : state == DONE ? IDLE : state;
        end
    end
    // storage keeps its last read byte across reset; rd_ok masks it to zero until a fresh read
    assign rd = rd_ok ? q : '0;
    mem_array #(.AW(AW)) u_mem (
        .clk(clk),
        .we (we),
        .re (re),
        .a  (a_n),
        .wd (d_n),
        .q  (q)
    );
endmodule
